// File: rtl/module_control_unit_if.sv
// Instruction handshake, ALU operand/result and display bundle of the mini-CPU control unit.
interface module_control_unit_if #(
    parameter int DATA_W = 16
);
    logic [17:0]       instr;
    logic              instr_valid;
    logic              instr_ready;
    logic [2:0]        alu_opcode;
    logic [DATA_W-1:0] alu_valor1;
    logic [DATA_W-1:0] alu_valor2;
    logic              alu_sinal_imm;
    logic [5:0]        alu_imm;
    logic [DATA_W-1:0] alu_saida;
    logic [DATA_W-1:0] disp_value;
    logic              done;

    modport master (
        output instr, instr_valid, alu_saida,
        input  instr_ready, alu_opcode, alu_valor1, alu_valor2, alu_sinal_imm, alu_imm,
               disp_value, done
    );

    modport slave (
        input  instr, instr_valid, alu_saida,
        output instr_ready, alu_opcode, alu_valor1, alu_valor2, alu_sinal_imm, alu_imm,
               disp_value, done
    );
endinterface

// File: rtl/module_control_unit.sv
// Mini-CPU instruction sequencer: decodes one instruction per handshake, drives the
// external ALU, waits out its latency and writes the result into a 16-entry register file.
module module_control_unit #(
    parameter int DATA_W  = 16,
    parameter int ALU_LAT = 2
) (
    input logic                  clk,
    input logic                  rst,
    module_control_unit_if.slave bus
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] READ = 3'd1;
    localparam logic [2:0] EXEC = 3'd2;
    localparam logic [2:0] CLR  = 3'd4;
    localparam logic [2:0] DONE = 3'd5;

    localparam logic [2:0] OP_CLEAR   = 3'b110;
    localparam logic [2:0] OP_DISPLAY = 3'b111;

    localparam int              CNT_W     = $clog2(ALU_LAT + 1) + 1;
    localparam logic [CNT_W-1:0] EXEC_LAST = CNT_W'(ALU_LAT);

    logic [2:0]        state;
    logic [17:0]       instr_q;
    logic [CNT_W-1:0]  exec_cnt;
    logic [3:0]        clr_cnt;
    logic [DATA_W-1:0] regs [16];

    logic [2:0]        alu_opcode_q;
    logic [DATA_W-1:0] alu_valor1_q;
    logic [DATA_W-1:0] alu_valor2_q;
    logic              alu_sinal_imm_q;
    logic [5:0]        alu_imm_q;
    logic [DATA_W-1:0] disp_value_q;

    logic [2:0] opcode;
    logic [3:0] dest;
    logic [3:0] src1;
    logic [3:0] src2;

    assign opcode = instr_q[17:15];
    assign dest   = instr_q[14:11];
    assign src1   = instr_q[10:7];
    assign src2   = instr_q[6:3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            instr_q         <= '0;
            exec_cnt        <= '0;
            clr_cnt         <= '0;
            alu_opcode_q    <= '0;
            alu_valor1_q    <= '0;
            alu_valor2_q    <= '0;
            alu_sinal_imm_q <= 1'b0;
            alu_imm_q       <= '0;
            disp_value_q    <= '0;
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.instr_valid) begin
                        instr_q <= bus.instr;
                        if (bus.instr[17:15] == OP_CLEAR) begin
                            clr_cnt <= '0;
                            state   <= CLR;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    // Operands are captured here, so a write to the same register later
                    // in this instruction cannot disturb the ALU inputs.
                    alu_opcode_q    <= opcode;
                    alu_valor1_q    <= regs[src1];
                    alu_valor2_q    <= regs[src2];
                    alu_sinal_imm_q <= instr_q[6];
                    alu_imm_q       <= instr_q[5:0];
                    if (opcode == OP_DISPLAY) begin
                        disp_value_q <= regs[src1];
                        state        <= DONE;
                    end else begin
                        exec_cnt <= '0;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    exec_cnt <= exec_cnt + 1'b1;
                    if (exec_cnt == EXEC_LAST) begin
                        regs[dest] <= bus.alu_saida;
                        state      <= DONE;
                    end
                end
                CLR: begin
                    regs[clr_cnt] <= '0;
                    clr_cnt       <= clr_cnt + 1'b1;
                    if (clr_cnt == 4'd15) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.instr_ready   = (state == IDLE);
    assign bus.done          = (state == DONE);
    assign bus.alu_opcode    = alu_opcode_q;
    assign bus.alu_valor1    = alu_valor1_q;
    assign bus.alu_valor2    = alu_valor2_q;
    assign bus.alu_sinal_imm = alu_sinal_imm_q;
    assign bus.alu_imm       = alu_imm_q;
    assign bus.disp_value    = disp_value_q;
endmodule
